fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first instruction word address fetched after reset.
REQ-002 SHALL have parameter INST_W, default 16, the instruction and PC width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1, the instruction memory request.
REQ-006 SHALL have port imem_addr, output, 16, the word address, held stable while imem_req=1.
REQ-007 SHALL have port imem_ack, input, 1; the transfer completes in any cycle where imem_req=1 and imem_ack=1.
REQ-008 SHALL have port imem_rdata, input, 16, the instruction word, valid with imem_ack.
REQ-009 SHALL have port inst_valid, output, 1; the buffer head is valid.
REQ-010 SHALL have port inst_ready, input, 1; the decode/control stage consumes the head.
REQ-011 SHALL have port inst, output, 16, the head instruction: opcode[15:12], Rd[11:8], Rs[7:4], Rt[3:0].
REQ-012 SHALL have port inst_pc, output, 16, the word address of the head instruction.
REQ-013 SHALL have port opcode, output, 4, inst[15:12], fed directly to the control unit.
REQ-014 SHALL have port inst_illegal, output, 1; asserted when inst_valid=1 and opcode is 4'b1110 or 4'b1111.
REQ-015 SHALL have port redirect, input, 1, a taken branch or jump from downstream.
REQ-016 SHALL have port redirect_pc, input, 16, the new fetch address, sampled when redirect=1.

Function
REQ-017 SHALL implement states FETCH (issue/hold request), DISCARD (complete the stale request and drop its data) and IDLE (buffer full, no request).
REQ-018 SHALL hold imem_req and imem_addr constant from assertion until imem_ack; no new request is issued before that, so at most one is outstanding.
REQ-019 SHALL assert imem_req only when registered buffer count plus outstanding count is less than DEPTH; otherwise it SHALL enter IDLE and leave it the cycle after a pop.
REQ-020 SHALL push imem_rdata and imem_addr into the buffer on ack in FETCH; inst_valid rises the cycle after the ack, with zero combinational path from imem_rdata to inst.
REQ-021 SHALL pop the head when inst_valid=1 and inst_ready=1; a push and a pop in the same cycle leave the count unchanged.
REQ-022 SHALL increment the fetch PC by 1 on each accepted ack, wrapping from 16'hFFFF to 16'h0000.
REQ-023 SHALL, on redirect=1, take priority over push and pop: empty the buffer, load the fetch PC with redirect_pc, and drive inst_valid=0 from the next cycle.
REQ-024 SHALL, on redirect while a request is unacknowledged, go to DISCARD, keep the old address until ack, drop that data, then go to FETCH with redirect_pc.
REQ-025 SHALL, on redirect in the same cycle as an ack, drop the acked data and request redirect_pc in the next cycle.
REQ-026 SHALL apply the last redirect when redirect is asserted in consecutive cycles.
REQ-027 SHALL sustain one instruction per cycle when imem_ack is combinational with imem_req, DEPTH=2, and inst_ready=1.

Reset
REQ-028 SHALL, while rst=1, drive imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, opcode=0 and inst_illegal=0, with the buffer empty and state FETCH.
REQ-029 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst falls.
REQ-030 SHALL abandon an in-flight request on reset mid-operation; the memory tolerates a dropped request.

Configuration
REQ-031 SHALL, when macro FETCH_PREFETCH_EN is defined, use buffer DEPTH=2, allowing a request while one entry is held.
REQ-032 SHALL, when FETCH_PREFETCH_EN is undefined, use DEPTH=1, so no request issues while inst_valid=1 (maximum throughput one instruction per two cycles).

Structure
REQ-033 SHALL take the following from shared package subarashii_pkg: opcode constants OP_ADD through OP_JAL (4'b0000 to 4'b1101), instruction field bit positions, INST_W, and the fetch state enum.
REQ-034 SHALL implement the buffer as sub-module fetch_buf: a parameterised-depth FIFO holding {pc, inst}, with flush input.

Verification
REQ-035 SHALL verify reset then start: release rst with ack tied 1 and ready 1 -> imem_addr 0,1,2,3 on consecutive cycles, and inst_pc 0,1,2 one cycle later.
REQ-036 SHALL verify backpressure: hold inst_ready=0 -> with DEPTH=2, exactly two acks and then imem_req=0; with DEPTH=1, one ack. No instruction is lost or duplicated after release.
REQ-037 SHALL verify redirect with a pending request: ack delayed 3 cycles, redirect to 16'h0040 in cycle 1 -> the old-address data is discarded and the next inst_pc is 16'h0040.
REQ-038 SHALL verify wrap: redirect to 16'hFFFF -> inst_pc sequence 16'hFFFF then 16'h0000.
REQ-039 SHALL verify illegal flag: imem_rdata 16'hE123 -> inst_illegal=1 and opcode=4'hE; 16'hD000 -> inst_illegal=0.
REQ-040 SHALL verify reset mid-stream: rst asserted with the buffer full and a request pending -> the next cycle has inst_valid=0 and imem_req=0, and after release the address restarts at RESET_PC.

Source files
------------

// File: rtl/subarashii_pkg.sv
// Shared definitions for the subarashii core: instruction fields, opcodes,
// fetch FSM states and the fetch buffer entry layout.
package subarashii_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned OPC_W  = 4;

  // Instruction field bit positions: opcode | Rd | Rs | Rt
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS_MSB  = 7;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned RT_MSB  = 3;
  localparam int unsigned RT_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SLL  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SRL  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b1000;
  localparam logic [OPC_W-1:0] OP_LW   = 4'b1001;
  localparam logic [OPC_W-1:0] OP_SW   = 4'b1010;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'b1101;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    IDLE    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Opcodes above OP_JAL are unassigned
  function automatic logic op_illegal(input logic [OPC_W-1:0] op);
    return op > OP_JAL;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Fetched-instruction FIFO of {pc, inst}. Entry 0 is always the head; slots
// shift down on pop and are zeroed when vacated, so an empty head reads as 0.
module fetch_buf
  import subarashii_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     din,
  output fetch_entry_t     head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] mid;

  // Next contents: flush wins, else pop shifts down and push lands after it
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    mid   = cnt_q;
    if (flush) begin
      mem_d = '{default: '0};
      cnt_d = '0;
    end else begin
      if (pop && (cnt_q != '0)) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
        mem_d[DEPTH-1] = '0;
        mid = cnt_q - 1'b1;
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CNT_W'(i) == mid) mem_d[i] = din;
        end
        cnt_d = mid + 1'b1;
      end else begin
        cnt_d = mid;
      end
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[0];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// instruction buffer, with redirect handling for taken branches/jumps.
// Define FETCH_PREFETCH_EN for a 2-entry buffer that fetches ahead while an
// instruction is held; otherwise the buffer holds a single entry.
module fetch_unit #(
  parameter int unsigned           INST_W   = subarashii_pkg::INST_W,
  parameter logic [INST_W-1:0]     RESET_PC = INST_W'(16'h0000)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req,
  output logic [INST_W-1:0]              imem_addr,
  input  logic                           imem_ack,
  input  logic [INST_W-1:0]              imem_rdata,
  output logic                           inst_valid,
  input  logic                           inst_ready,
  output logic [INST_W-1:0]              inst,
  output logic [INST_W-1:0]              inst_pc,
  output logic [subarashii_pkg::OPC_W-1:0] opcode,
  output logic                           inst_illegal,
  input  logic                           redirect,
  input  logic [INST_W-1:0]              redirect_pc
);
  import subarashii_pkg::*;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic             req_q, req_d;
  logic [INST_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] pend_q, pend_d;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_pop;
  fetch_entry_t     entry_in;
  fetch_entry_t     head;

  // Next state, request and address; redirect outranks push and pop
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    push    = 1'b0;
    accept  = req_q && imem_ack;
    pop     = inst_valid && inst_ready;
    cnt_pop = pop ? cnt - 1'b1 : cnt;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (req_q && !imem_ack) begin
            // Stale request must still complete at its old address
            state_d = DISCARD;
            pend_d  = redirect_pc;
          end else begin
            addr_d = redirect_pc;
            req_d  = 1'b1;
          end
        end else if (accept) begin
          push    = 1'b1;
          addr_d  = addr_q + 1'b1;
          req_d   = (cnt_pop + 1'b1) < CNT_W'(DEPTH);
          state_d = req_d ? FETCH : IDLE;
        end else if (!req_q) begin
          req_d   = cnt_pop < CNT_W'(DEPTH);
          state_d = req_d ? FETCH : IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = redirect ? redirect_pc : pend_q;
        end else if (redirect) begin
          pend_d = redirect_pc;
        end
      end
      IDLE: begin
        if (redirect) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
        end else if (cnt_pop < CNT_W'(DEPTH)) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM, request and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pend_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  assign entry_in = '{pc: addr_q, inst: imem_rdata};

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (entry_in),
    .head  (head),
    .valid (inst_valid),
    .count (cnt)
  );

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign inst         = head.inst;
  assign inst_pc      = head.pc;
  assign opcode       = head.inst[OPC_MSB:OPC_LSB];
  assign inst_illegal = inst_valid && op_illegal(opcode);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Buffer depth follows FETCH_PREFETCH_EN.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk, rst, imem_req, imem_ack, inst_valid, inst_ready;
  logic        inst_illegal, redirect;
  logic [15:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
  logic [3:0]  opcode;
  logic        ovr_en;
  logic [15:0] ovr_val;
  int          n_checks = 0;
  int          n_pass = 0;

  // Memory contents: a fixed scramble of the address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hC3A5;
  endfunction

  assign imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .inst_illegal(inst_illegal), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0; ovr_en = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic        exp_req, exp_valid;
    logic [15:0] exp_addr, exp_ipc;
    rst = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1; redirect = 1'b0; ovr_en = 1'b0;
    redirect_pc = 16'h0;
    cyc(); cyc();
    n_checks++; if ({imem_req, inst_valid, inst_illegal} !== 3'b000)
      $display("FAIL reset_ctrl: req/valid/illegal=%b want 000", {imem_req, inst_valid, inst_illegal});
    else n_pass++;
    n_checks++; if (imem_addr !== RST_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC);
    else n_pass++;
    n_checks++; if ({inst, inst_pc, opcode} !== 36'h0)
      $display("FAIL reset_data: inst=%h pc=%h op=%h want 0", inst, inst_pc, opcode);
    else n_pass++;
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 7; k++) begin
      if (DEPTH == 2) begin
        exp_req = 1'b1; exp_addr = RST_PC + 16'(k);
        exp_valid = (k >= 1); exp_ipc = RST_PC + 16'(k) - 16'd1;
      end else begin
        exp_req = (k % 2 == 0); exp_addr = RST_PC + 16'(k / 2);
        exp_valid = (k % 2 == 1); exp_ipc = RST_PC + 16'(k / 2);
      end
      n_checks++; if (imem_req !== exp_req) $display("FAIL start_req c%0d: got %b want %b", k, imem_req, exp_req);
      else n_pass++;
      if (exp_req) begin
        n_checks++; if (imem_addr !== exp_addr) $display("FAIL start_addr c%0d: got %h want %h", k, imem_addr, exp_addr);
        else n_pass++;
      end
      n_checks++; if (inst_valid !== exp_valid) $display("FAIL start_valid c%0d: got %b want %b", k, inst_valid, exp_valid);
      else n_pass++;
      if (exp_valid) begin
        n_checks++; if (inst_pc !== exp_ipc) $display("FAIL start_pc c%0d: got %h want %h", k, inst_pc, exp_ipc);
        else n_pass++;
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int          acks, npop;
    logic [15:0] exp;
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b0; acks = 0;
    for (int k = 0; k < 8; k++) begin
      if (imem_req && imem_ack) acks++;
      cyc();
    end
    n_checks++; if (acks != DEPTH) $display("FAIL bp_acks: got %0d want %0d", acks, DEPTH);
    else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_req: got %b want 0", imem_req);
    else n_pass++;
    inst_ready = 1'b1; exp = RST_PC; npop = 0;
    for (int k = 0; k < 16; k++) begin
      if (inst_valid) begin
        n_checks++; if (inst_pc !== exp) $display("FAIL bp_pc: got %h want %h", inst_pc, exp);
        else n_pass++;
        n_checks++; if (inst !== mem_word(exp)) $display("FAIL bp_inst: got %h want %h", inst, mem_word(exp));
        else n_pass++;
        exp = exp + 16'd1; npop++;
      end
      cyc();
    end
    n_checks++; if (npop < 6) $display("FAIL bp_drain: got %0d pops want >= 6", npop);
    else n_pass++;
  endtask

  task automatic test_redirect_pending();
    do_reset();
    imem_ack = 1'b0; inst_ready = 1'b1;
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, RST_PC})
      $display("FAIL rp_first: req/addr=%b/%h want 1/%h", imem_req, imem_addr, RST_PC);
    else n_pass++;
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if ({imem_req, imem_addr} !== {1'b1, RST_PC})
        $display("FAIL rp_hold c%0d: req/addr=%b/%h want 1/%h", k, imem_req, imem_addr, RST_PC);
      else n_pass++;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL rp_empty c%0d: got %b want 0", k, inst_valid);
      else n_pass++;
      if (k == 0) cyc();
    end
    imem_ack = 1'b1;
    cyc();
    n_checks++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, 16'h0040, 1'b0})
      $display("FAIL rp_newreq: req/addr/valid=%b/%h/%b want 1/0040/0", imem_req, imem_addr, inst_valid);
    else n_pass++;
    for (int k = 0; k < 10 && !inst_valid; k++) cyc();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0040)
      $display("FAIL rp_pc: valid/pc=%b/%h want 1/0040", inst_valid, inst_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int          n;
    logic [15:0] got [2];
    imem_ack = 1'b1; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    redirect = 1'b0; n = 0; got[0] = 16'h1; got[1] = 16'h1;
    for (int k = 0; k < 20 && n < 2; k++) begin
      if (inst_valid) begin got[n] = inst_pc; n++; end
      cyc();
    end
    n_checks++; if (n != 2) $display("FAIL wrap_count: got %0d want 2", n);
    else n_pass++;
    n_checks++; if (got[0] !== 16'hFFFF) $display("FAIL wrap_first: got %h want ffff", got[0]);
    else n_pass++;
    n_checks++; if (got[1] !== 16'h0000) $display("FAIL wrap_second: got %h want 0000", got[1]);
    else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    inst_ready = 1'b0; ovr_en = 1'b1; ovr_val = 16'hE123; imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    n_checks++; if ({inst_valid, inst_illegal, opcode, inst} !== {1'b1, 1'b1, 4'hE, 16'hE123})
      $display("FAIL ill_e: valid/ill/op/inst=%b/%b/%h/%h want 1/1/e/e123", inst_valid, inst_illegal, opcode, inst);
    else n_pass++;
    inst_ready = 1'b1; ovr_val = 16'hD000;
    cyc();
    inst_ready = 1'b0; imem_ack = 1'b1;
    for (int k = 0; k < 10 && !inst_valid; k++) cyc();
    n_checks++; if ({inst_valid, inst_illegal, opcode, inst} !== {1'b1, 1'b0, 4'hD, 16'hD000})
      $display("FAIL ill_d: valid/ill/op/inst=%b/%b/%h/%h want 1/0/d/d000", inst_valid, inst_illegal, opcode, inst);
    else n_pass++;
    ovr_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic exp_req;
    exp_req = (DEPTH == 2);
    redirect = 1'b1; redirect_pc = 16'h0200; imem_ack = 1'b1; inst_ready = 1'b0;
    cyc();
    redirect = 1'b0;
    cyc();
    imem_ack = 1'b0;
    cyc();
    n_checks++; if ({inst_valid, inst_pc, imem_req} !== {1'b1, 16'h0200, exp_req})
      $display("FAIL mid_pre: valid/pc/req=%b/%h/%b want 1/0200/%b", inst_valid, inst_pc, imem_req, exp_req);
    else n_pass++;
    rst = 1'b1;
    cyc();
    n_checks++; if ({inst_valid, imem_req} !== 2'b00)
      $display("FAIL mid_rst: valid/req=%b/%b want 0/0", inst_valid, imem_req);
    else n_pass++;
    rst = 1'b0;
    cyc();
    n_checks++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, RST_PC, 1'b0})
      $display("FAIL mid_restart: req/addr/valid=%b/%h/%b want 1/%h/0", imem_req, imem_addr, inst_valid, RST_PC);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int npop;
    // Consecutive redirects with immediate acks
    imem_ack = 1'b1; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0300; cyc();
    redirect_pc = 16'h0500; cyc();
    redirect = 1'b0;
    for (int k = 0; k < 10 && !inst_valid; k++) cyc();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0500)
      $display("FAIL b2b_ack: valid/pc=%b/%h want 1/0500", inst_valid, inst_pc);
    else n_pass++;
    // Consecutive redirects while the memory stalls
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0600; cyc();
    redirect_pc = 16'h0700; cyc();
    redirect = 1'b0; cyc();
    imem_ack = 1'b1;
    for (int k = 0; k < 10 && !inst_valid; k++) cyc();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0700)
      $display("FAIL b2b_stall: valid/pc=%b/%h want 1/0700", inst_valid, inst_pc);
    else n_pass++;
    // Steady-state throughput
    cyc(); cyc(); cyc();
    npop = 0;
    for (int k = 0; k < 10; k++) begin
      if (inst_valid && inst_ready) npop++;
      cyc();
    end
    n_checks++; if (npop != ((DEPTH == 2) ? 10 : 5))
      $display("FAIL b2b_rate: got %0d pops want %0d", npop, (DEPTH == 2) ? 10 : 5);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] exp_pc, prev_addr;
    logic        chk_empty, prev_hold, exp_ill;
    int          npop;
    exp_pc = 16'h1230; imem_ack = 1'b1; inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = exp_pc;
    cyc();
    redirect = 1'b0; chk_empty = 1'b1; prev_hold = 1'b0; prev_addr = 16'h0; npop = 0;
    for (int c = 0; c < 3000; c++) begin
      if (chk_empty) begin
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rnd_flush c%0d: valid=%b want 0", c, inst_valid);
        else n_pass++;
      end
      if (prev_hold) begin
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, prev_addr})
          $display("FAIL rnd_hold c%0d: req/addr=%b/%h want 1/%h", c, imem_req, imem_addr, prev_addr);
        else n_pass++;
      end
      exp_ill = inst_valid && (opcode >= 4'hE);
      n_checks++; if (inst_illegal !== exp_ill || opcode !== inst[15:12])
        $display("FAIL rnd_dec c%0d: ill/op=%b/%h inst=%h want ill %b", c, inst_illegal, opcode, inst, exp_ill);
      else n_pass++;
      imem_ack    = ($urandom_range(3) != 0);
      inst_ready  = ($urandom_range(2) != 0);
      redirect    = ($urandom_range(40) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom);
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (inst_valid && inst_ready) begin
        n_checks++; if (inst_pc !== exp_pc || inst !== mem_word(exp_pc))
          $display("FAIL rnd_pop c%0d: pc/inst=%h/%h want %h/%h", c, inst_pc, inst, exp_pc, mem_word(exp_pc));
        else n_pass++;
        exp_pc = exp_pc + 16'd1; npop++;
      end
      chk_empty = redirect;
      prev_hold = imem_req && !imem_ack;
      prev_addr = imem_addr;
      cyc();
    end
    redirect = 1'b0;
    n_checks++; if (npop < 200) $display("FAIL rnd_progress: got %0d pops want >= 200", npop);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_pending();
    test_wrap();
    test_illegal();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
